// File: rtl/micron_sram_responder_pkg.sv
// Shared bus constants for the Micron-style burst SRAM responder.
package micron_sram_responder_pkg;

    // Bus levels for active-high and active-low strobes
    localparam logic ASSERT     = 1'b1;
    localparam logic DEASSERT   = 1'b0;
    localparam logic ASSERT_L   = 1'b0;
    localparam logic DEASSERT_L = 1'b1;

    // Responder FSM encodings
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    // Latency config: reset value and its field within maddr on a config write
    localparam int DEF_LATENCY = 4;
    localparam int LAT_LSB     = 0;
    localparam int LAT_MSB     = 2;
    localparam int LAT_WIDTH   = LAT_MSB - LAT_LSB + 1;

    localparam logic [LAT_WIDTH-1:0] MIN_LATENCY = LAT_WIDTH'(2);

    // Latencies below two cannot be honoured by the WAIT countdown, so clamp them
    function automatic logic [LAT_WIDTH-1:0] clamp_latency(input logic [LAT_WIDTH-1:0] req);
        return (req < MIN_LATENCY) ? MIN_LATENCY : req;
    endfunction

endpackage

// File: rtl/micron_sram_responder_sram_array.sv
// Single-port word array: synchronous write, asynchronous read. Contents survive reset.
module micron_sram_responder_sram_array #(
    parameter int A_WIDTH = 16,
    parameter int D_WIDTH = 16
) (
    input  logic               clk,
    input  logic               we,
    input  logic [A_WIDTH-1:0] addr,
    input  logic [D_WIDTH-1:0] wdata,
    output logic [D_WIDTH-1:0] rdata
);
    import micron_sram_responder_pkg::*;

    logic [D_WIDTH-1:0] mem [0:(1 << A_WIDTH) - 1];

    // Commit one word per write-enabled edge
    always_ff @(posedge clk) begin
        if (we == ASSERT) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/micron_sram_responder.sv
// Device end of a Micron-style synchronous burst SRAM bus.
//
// state | meaning
// IDLE  | no access in flight; accepts address cycles and config writes
// WAIT  | latency count after address capture, mwait high
// DATA  | one word per cycle; reads drive mdata, writes commit mdata
module micron_sram_responder #(
    parameter int A_WIDTH     = 16,
    parameter int D_WIDTH     = 16,
    parameter int DEF_LATENCY = micron_sram_responder_pkg::DEF_LATENCY
) (
    input  logic               clk50MHz,
    input  logic               rst_L,
    input  logic [A_WIDTH-1:0] maddr,
    inout  wire  [D_WIDTH-1:0] mdata,
    input  logic               madv_L,
    input  logic               mce_L,
    input  logic               mwe_L,
    input  logic               moe_L,
    input  logic               mcre,
    output logic               mwait
);
    import micron_sram_responder_pkg::*;

    logic [1:0]           state;
    logic [A_WIDTH-1:0]   addr_reg;
    logic                 wr_reg;
    logic [LAT_WIDTH-1:0] latency_reg;
    logic [LAT_WIDTH-1:0] cnt;
    logic [D_WIDTH-1:0]   rd_word;
    logic                 addr_cycle;
    logic                 restart;
    logic                 cfg_write;
    logic                 mem_we;
    logic                 data_oe;

    assign addr_cycle = (mce_L == ASSERT_L) && (madv_L == ASSERT_L);
    // Only a memory address cycle starts or restarts an access
    assign restart    = addr_cycle && (mcre == DEASSERT);
    assign cfg_write  = addr_cycle && (mcre == ASSERT) && (mwe_L == ASSERT_L);
    // A restart edge takes the bus over, so the in-flight write word is dropped
    assign mem_we     = (state == DATA) && wr_reg && (mce_L == ASSERT_L) && !restart;

    // Live moe_L/mce_L gate the driver so the bus turns around in the same cycle
    assign data_oe = (state == DATA) && !wr_reg && (moe_L == ASSERT_L) && (mce_L == ASSERT_L);
    assign mdata   = data_oe ? rd_word : {D_WIDTH{1'bz}};
    assign mwait   = (state == WAIT);

    // Access sequencing: deselect abort, restart on address cycle, then normal flow
    always_ff @(posedge clk50MHz or negedge rst_L) begin
        if (!rst_L) begin
            state       <= IDLE;
            addr_reg    <= '0;
            wr_reg      <= 1'b0;
            cnt         <= '0;
            latency_reg <= clamp_latency(LAT_WIDTH'(DEF_LATENCY));
        end else if (mce_L == DEASSERT_L) begin
            state <= IDLE;
        end else if (restart) begin
            addr_reg <= maddr;
            wr_reg   <= ~mwe_L;
            cnt      <= LAT_WIDTH'(1);
            state    <= WAIT;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_write) begin
                        latency_reg <= clamp_latency(maddr[LAT_MSB:LAT_LSB]);
                    end
                end
                WAIT: begin
                    cnt <= cnt + LAT_WIDTH'(1);
                    if (cnt == latency_reg - LAT_WIDTH'(1)) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    addr_reg <= addr_reg + A_WIDTH'(1);
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    micron_sram_responder_sram_array #(
        .A_WIDTH (A_WIDTH),
        .D_WIDTH (D_WIDTH)
    ) u_sram_array (
        .clk   (clk50MHz),
        .we    (mem_we),
        .addr  (addr_reg),
        .wdata (mdata),
        .rdata (rd_word)
    );

endmodule

// File: tb/tb_micron_sram_responder.sv
// Bench for micron_sram_responder: directed scenarios then randomized config/write/read rounds.
module tb_micron_sram_responder;

    logic        clk50MHz = 1'b0;
    logic        rst_L;
    logic [15:0] maddr;
    wire  [15:0] mdata;
    logic        madv_L;
    logic        mce_L;
    logic        mwe_L;
    logic        moe_L;
    logic        mcre;
    logic        mwait;

    logic        tb_drv;
    logic [15:0] tb_val;

    int tests = 0;
    int fails = 0;

    // Reference: flat word memory plus the latency the responder should currently apply
    logic [15:0] model [0:65535];
    int          cur_lat;
    logic [15:0] wbuf [0:7];

    assign mdata = tb_drv ? tb_val : 16'hzzzz;

    always #10 clk50MHz = ~clk50MHz;

    micron_sram_responder #(
        .A_WIDTH     (16),
        .D_WIDTH     (16),
        .DEF_LATENCY (4)
    ) dut (
        .clk50MHz (clk50MHz),
        .rst_L    (rst_L),
        .maddr    (maddr),
        .mdata    (mdata),
        .madv_L   (madv_L),
        .mce_L    (mce_L),
        .mwe_L    (mwe_L),
        .moe_L    (moe_L),
        .mcre     (mcre),
        .mwait    (mwait)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        maddr  = 16'h0000;
        madv_L = 1'b1;
        mce_L  = 1'b1;
        mwe_L  = 1'b1;
        moe_L  = 1'b1;
        mcre   = 1'b0;
        tb_drv = 1'b0;
        tb_val = 16'h0000;
    endtask

    // The responder is released if a zero driven by the bench reads back as zero
    task automatic check_released(input string tag);
        tb_drv = 1'b1;
        tb_val = 16'h0000;
        #1;
        chk(tag, 32'(mdata), 32'h0);
        tb_drv = 1'b0;
        #1;
    endtask

    task automatic addr_cycle(input logic [15:0] a, input logic we, input logic cre);
        maddr  = a;
        mce_L  = 1'b0;
        madv_L = 1'b0;
        mwe_L  = ~we;
        mcre   = cre;
        @(negedge clk50MHz);
        madv_L = 1'b1;
        mwe_L  = 1'b1;
        mcre   = 1'b0;
    endtask

    task automatic config_latency(input logic [2:0] v);
        addr_cycle({13'($urandom), v}, 1'b1, 1'b1);
        mce_L = 1'b1;
        @(negedge clk50MHz);
        cur_lat = (v < 3'd2) ? 2 : int'(v);
    endtask

    task automatic wait_latency(input string tag);
        int waits;
        waits = 0;
        while (mwait === 1'b1 && waits < 16) begin
            waits++;
            @(negedge clk50MHz);
        end
        chk(tag, 32'(waits), 32'(cur_lat - 1));
    endtask

    task automatic write_words(input logic [15:0] a, input int n);
        logic [15:0] wa;
        for (int i = 0; i < n; i++) begin
            tb_drv = 1'b1;
            tb_val = wbuf[i];
            @(negedge clk50MHz);
            wa = a + 16'(i);
            model[wa] = wbuf[i];
        end
    endtask

    task automatic read_words(input logic [15:0] a, input int n, input string tag);
        logic [15:0] ra;
        moe_L = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            ra = a + 16'(i);
            chk($sformatf("%s[%0d]", tag, i), 32'(mdata), 32'(model[ra]));
            @(negedge clk50MHz);
        end
    endtask

    task automatic write_burst(input logic [15:0] a, input int n, input string tag);
        addr_cycle(a, 1'b1, 1'b0);
        wait_latency({tag, "_lat"});
        write_words(a, n);
        mce_L  = 1'b1;
        tb_drv = 1'b0;
        @(negedge clk50MHz);
    endtask

    task automatic finish_read(input string tag);
        moe_L = 1'b1;
        check_released({tag, "_oe_release"});
        moe_L = 1'b0;
        mce_L = 1'b1;
        check_released({tag, "_ce_release"});
        @(negedge clk50MHz);
        moe_L = 1'b1;
        chk({tag, "_idle_mwait"}, 32'(mwait), 32'h0);
    endtask

    task automatic read_burst(input logic [15:0] a, input int n, input string tag);
        addr_cycle(a, 1'b0, 1'b0);
        wait_latency({tag, "_lat"});
        read_words(a, n, tag);
        finish_read(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra;
        int          n;

        // Reset then idle
        rst_L = 1'b0;
        bus_idle();
        cur_lat = 4;
        #5;
        chk("reset_mwait", 32'(mwait), 32'h0);
        check_released("reset_mdata");
        @(negedge clk50MHz);
        rst_L = 1'b1;
        @(negedge clk50MHz);

        // Write burst at 0x0010 with default latency, then read it back
        wbuf[0] = 16'hA001; wbuf[1] = 16'hA002; wbuf[2] = 16'hA003; wbuf[3] = 16'hA004;
        write_burst(16'h0010, 4, "wr10");
        read_burst(16'h0010, 4, "rd10");

        // Config latency 6, then clamp of 0 to 2
        config_latency(3'd6);
        read_burst(16'h0010, 2, "rd_lat6");
        config_latency(3'd0);
        read_burst(16'h0011, 3, "rd_lat2");

        // Reset during WAIT drops mwait at once and restores default latency
        addr_cycle(16'h0010, 1'b0, 1'b0);
        chk("wait_mwait", 32'(mwait), 32'h1);
        #3;
        rst_L = 1'b0;
        #1;
        chk("wait_reset_mwait", 32'(mwait), 32'h0);
        @(negedge clk50MHz);
        rst_L = 1'b1;
        bus_idle();
        cur_lat = 4;
        @(negedge clk50MHz);

        // Reset during a read DATA phase releases the bus at once
        addr_cycle(16'h0010, 1'b0, 1'b0);
        wait_latency("rd_rst_lat");
        read_words(16'h0010, 2, "rd_rst");
        #3;
        rst_L = 1'b0;
        check_released("data_reset_mdata");
        chk("data_reset_mwait", 32'(mwait), 32'h0);
        @(negedge clk50MHz);
        rst_L = 1'b1;
        bus_idle();
        @(negedge clk50MHz);

        // Partial write burst cut by reset keeps the committed words only
        wbuf[0] = 16'h0BA0; wbuf[1] = 16'h0BA1; wbuf[2] = 16'h0BA2; wbuf[3] = 16'h0BA3;
        write_burst(16'h0030, 4, "pre30");
        wbuf[0] = 16'h3001; wbuf[1] = 16'h3002;
        addr_cycle(16'h0030, 1'b1, 1'b0);
        wait_latency("part_lat");
        write_words(16'h0030, 2);
        tb_val = 16'h3003;
        #3;
        rst_L = 1'b0;
        @(negedge clk50MHz);
        rst_L = 1'b1;
        bus_idle();
        @(negedge clk50MHz);
        read_burst(16'h0030, 4, "rd30");

        // Address wrap at the top of the array
        wbuf[0] = 16'h0001; wbuf[1] = 16'h0002; wbuf[2] = 16'h0003;
        write_burst(16'hFFFE, 3, "wr_wrap");
        read_burst(16'hFFFE, 3, "rd_wrap");
        read_burst(16'h0000, 1, "rd_zero");

        // Deselect during WAIT aborts with no write
        wbuf[0] = 16'h1234;
        write_burst(16'h0040, 1, "wr40");
        addr_cycle(16'h0040, 1'b1, 1'b0);
        chk("abort_mwait_on", 32'(mwait), 32'h1);
        tb_drv = 1'b1;
        tb_val = 16'hDEAD;
        mce_L  = 1'b1;
        @(negedge clk50MHz);
        chk("abort_mwait_off", 32'(mwait), 32'h0);
        repeat (6) @(negedge clk50MHz);
        tb_drv = 1'b0;
        read_burst(16'h0040, 1, "rd40");

        // New address cycle during DATA restarts at the new address
        wbuf[0] = 16'h2001; wbuf[1] = 16'h2002; wbuf[2] = 16'h2003;
        write_burst(16'h0020, 3, "wr20");
        wbuf[0] = 16'h0101; wbuf[1] = 16'h0102; wbuf[2] = 16'h0103;
        write_burst(16'h0100, 3, "wr100");
        addr_cycle(16'h0020, 1'b0, 1'b0);
        wait_latency("rs_lat1");
        read_words(16'h0020, 2, "rs_first");
        addr_cycle(16'h0100, 1'b0, 1'b0);
        chk("restart_mwait", 32'(mwait), 32'h1);
        wait_latency("rs_lat2");
        read_words(16'h0100, 3, "rs_second");
        finish_read("rs");

        // Randomized rounds: latency config, write burst, read back
        for (int it = 0; it < 12; it++) begin
            config_latency(3'($urandom_range(0, 7)));
            ra = 16'($urandom);
            n  = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin
                wbuf[i] = 16'($urandom_range(1, 65535));
            end
            write_burst(ra, n, $sformatf("rnd_wr%0d", it));
            read_burst(ra, n, $sformatf("rnd_rd%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/micron_sram_responder.md
Name: micron_sram_responder

Overview:
- Synthesizable responder for the Micron-style synchronous burst SRAM bus. It is the memory-device end of the bus that the SRAM controller drives.
- It decodes maddr/madv_L/mce_L/mwe_L/moe_L/mcre, applies the configured read/write latency with mwait, then streams burst data from or into an internal word array.
- It serves as the on-chip stand-in for the external part in system simulation and FPGA bring-up.

Parameters:
- A_WIDTH, 16, address width; array depth is 2^A_WIDTH words.
- D_WIDTH, 16, data word width.
- DEF_LATENCY, 4, reset value of the latency config register, in cycles from address capture to first data cycle.

Ports:
- clk50MHz  in  1  system clock; all state updates on its posedge.
- rst_L  in  1  asynchronous, active-low reset.
- maddr  in  A_WIDTH  word address; sampled only on the address cycle.
- mdata  inout  D_WIDTH  data bus; driven only during read data cycles, high-Z otherwise.
- madv_L  in  1  address valid, active-low.
- mce_L  in  1  chip enable, active-low.
- mwe_L  in  1  write enable, active-low; sampled on the address cycle.
- moe_L  in  1  output enable, active-low.
- mcre  in  1  control register enable; sampled on the address cycle.
- mwait  out  1  active-high; asserted while the access is in latency wait.

Behaviour:
- Reset (rst_L=0, asynchronous): state=IDLE, mwait=0, mdata=Z, latency_reg=DEF_LATENCY, addr_reg=0, wr_reg=0, cnt=0. Array contents are not cleared.
- Address cycle: posedge with mce_L=0 and madv_L=0. Captures addr_reg=maddr, wr_reg=~mwe_L and cnt=1.
- States:
  - IDLE: on an address cycle with mcre=0, go to WAIT. On an address cycle with mcre=1 and mwe_L=0, perform a config write: latency_reg = max(maddr[2:0], 2) and stay in IDLE. An address cycle with mcre=1 and mwe_L=1 is ignored.
  - WAIT: mwait=1. cnt increments each posedge. When cnt==latency_reg-1 at the posedge, go to DATA. First data cycle is therefore exactly latency_reg cycles after the address edge (4 with the default).
  - DATA: mwait=0, one word per cycle. Read: mdata = array[addr_reg] while wr_reg=0, moe_L=0 and mce_L=0; else Z. Write: at each posedge in DATA, array[addr_reg] <= mdata. addr_reg increments every DATA posedge and wraps from 2^A_WIDTH-1 to 0. DATA continues until mce_L=1; there is no internal burst length limit.
- Priority at each posedge, in order:
  1. mce_L=1 forces IDLE from any state and aborts the access with no write on that edge.
  2. A new address cycle in WAIT or DATA restarts the access: recapture addr_reg and wr_reg, go to WAIT. A config write in WAIT or DATA is ignored.
  3. Normal transition.
- mdata output enable is a combinational decode of registered state/wr_reg and the live moe_L/mce_L. Bus turnaround: enable drops in the same cycle moe_L rises.
- Reset asserted mid-burst: immediate IDLE and mdata=Z. A partially written burst keeps the words already committed.
- Latency values 0/1 written to config are clamped to 2. latency_reg changes apply from the next access only.

Decomposition:
- Shared package/header holds the bus constants: ASSERT/DEASSERT/ASSERT_L/DEASSERT_L, state encodings IDLE/WAIT/DATA, DEF_LATENCY, and the latency field position maddr[2:0].
- One sub-module, sram_array: single-port word array with synchronous write and asynchronous read, parameters A_WIDTH/D_WIDTH. The responder holds the FSM, counters and tristate.

Test Plan:
- Reset then idle: rst_L low mid-cycle -> mwait=0 and mdata=Z immediately; latency_reg=4.
- Write burst: address cycle maddr=16'h0010, mwe_L=0; drive 16'hA001..A004 on the 4 DATA cycles starting at edge+4, then mce_L=1 -> array[0x10..0x13]=A001..A004, and mwait=1 for exactly 3 cycles.
- Read burst: address cycle maddr=16'h0010, mwe_L=1; moe_L=0 in DATA -> mdata=A001, A002, A003, A004 on consecutive cycles starting at edge+4; Z after mce_L=1.
- Config write: mcre=1, mwe_L=0, maddr[2:0]=3'd6 -> next read's first data at edge+6. Then maddr[2:0]=0 -> first data at edge+2 (clamp).
- Address wrap: write burst at 16'hFFFE with data 1, 2, 3 -> array[FFFE]=1, array[FFFF]=2, array[0000]=3.
- Abort and restart: mce_L=1 during WAIT -> IDLE with no write. New madv_L cycle during DATA at 16'h0100 -> mwait reasserts, data resumes at the new address after latency.
